// File: rtl/carry_lookahead_32bit_if.sv
// Operand/result bundle for the 32-bit lookahead adder.
// The master drives the operands. The slave (the adder) returns the registered sum.
interface carry_lookahead_32bit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic [31:0] Sum;
    logic        Cout;

    modport master (output A, output B, output Cin, input Sum, input Cout);
    modport slave  (input A, input B, input Cin, output Sum, output Cout);
endinterface

// File: rtl/carry_lookahead_32bit.sv
// Two-level carry-lookahead 32-bit adder with a registered Sum/Cout stage.
// Level 1 uses eight 4-bit blocks. Level 2 uses two 4-group units. A top combine produces the unit carries and Cout.
module carry_lookahead_32bit (
    input  logic                    clk,
    input  logic                    rst_n,
    carry_lookahead_32bit_if.slave  bus
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [7:0]  bc;
    logic [1:0]  sg;
    logic [1:0]  sp;
    logic [2:0]  uc;

    logic [31:0] sum_d;
    logic [31:0] sum_q;
    logic        cout_d;
    logic        cout_q;

    assign g = bus.A & bus.B;
    assign p = bus.A ^ bus.B;

    // Level 1: each 4-bit block expands its carries from the block carry-in bc.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_blk
            localparam int B0 = 4 * gi;
            assign c[B0]   = bc[gi];
            assign c[B0+1] = g[B0] | (p[B0] & bc[gi]);
            assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0])
                           | (p[B0+1] & p[B0] & bc[gi]);
            assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1])
                           | (p[B0+2] & p[B0+1] & g[B0])
                           | (p[B0+2] & p[B0+1] & p[B0] & bc[gi]);
            assign gg[gi]  = g[B0+3] | (p[B0+3] & g[B0+2])
                           | (p[B0+3] & p[B0+2] & g[B0+1])
                           | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
            assign gp[gi]  = &p[B0+3:B0];
        end

        // Level 2: each unit produces the carry-ins for its four blocks from GG/GP.
        for (gi = 0; gi < 2; gi++) begin : g_unit
            localparam int U0 = 4 * gi;
            assign bc[U0]   = uc[gi];
            assign bc[U0+1] = gg[U0] | (gp[U0] & uc[gi]);
            assign bc[U0+2] = gg[U0+1] | (gp[U0+1] & gg[U0])
                            | (gp[U0+1] & gp[U0] & uc[gi]);
            assign bc[U0+3] = gg[U0+2] | (gp[U0+2] & gg[U0+1])
                            | (gp[U0+2] & gp[U0+1] & gg[U0])
                            | (gp[U0+2] & gp[U0+1] & gp[U0] & uc[gi]);
            assign sg[gi]   = gg[U0+3] | (gp[U0+3] & gg[U0+2])
                            | (gp[U0+3] & gp[U0+2] & gg[U0+1])
                            | (gp[U0+3] & gp[U0+2] & gp[U0+1] & gg[U0]);
            assign sp[gi]   = &gp[U0+3:U0];
        end
    endgenerate

    assign uc[0] = bus.Cin;
    assign uc[1] = sg[0] | (sp[0] & bus.Cin);
    assign uc[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & bus.Cin);

    assign sum_d  = p ^ c;
    assign cout_d = uc[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 32'h0000_0000;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_carry_lookahead_32bit.sv
// Bench for carry_lookahead_32bit. It runs directed vectors, then random vectors.
// Each result is compared with the 33-bit arithmetic sum A + B + Cin.
module tb_carry_lookahead_32bit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    carry_lookahead_32bit_if bus ();

    carry_lookahead_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic [31:0] exp_s, input logic exp_c);
        checks++;
        assert (bus.Sum === exp_s) else begin
            failures++;
            $error("FAIL %s sum got=%h exp=%h", tag, bus.Sum, exp_s);
        end
        checks++;
        assert (bus.Cout === exp_c) else begin
            failures++;
            $error("FAIL %s cout got=%b exp=%b", tag, bus.Cout, exp_c);
        end
        $display("%s A=%h B=%h Cin=%b -> Sum=%h Cout=%b", tag, bus.A, bus.B, bus.Cin, bus.Sum, bus.Cout);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
    endtask

    // Applies one vector and checks it one edge later against the 33-bit sum.
    task automatic add_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin);
        logic [32:0] ref_v;
        ref_v = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        drive(a, b, cin);
        @(posedge clk);
        #1;
        check_out(tag, ref_v[31:0], ref_v[32]);
    endtask

    // Applies one vector and checks it against literal expected values.
    task automatic add_const(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic [31:0] exp_s, input logic exp_c);
        drive(a, b, cin);
        @(posedge clk);
        #1;
        check_out(tag, exp_s, exp_c);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(32'h1234_5678, 32'h1111_1111, 1'b1);
        @(posedge clk);
        #1;
        check_out("reset_state", 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        add_const("smax_plus1",  32'h7FFF_FFFF, 32'h1,         1'b0, 32'h8000_0000, 1'b0);
        add_const("min_plus_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
        add_const("5_plus_m3",   32'd5,         -32'sd3,       1'b0, 32'd2,         1'b1);
        add_const("7_plus_3",    32'd7,         32'd3,         1'b0, 32'd10,        1'b0);
        add_const("m15_plus_20", -32'sd15,      32'd20,        1'b0, 32'd5,         1'b1);
        add_const("m4_plus_m6",  -32'sd4,       -32'sd6,       1'b0, 32'hFFFF_FFF6, 1'b1);
        add_const("12_m8_cin",   32'd12,        -32'sd8,       1'b1, 32'd5,         1'b1);
        add_const("zero_cin",    32'd0,         32'd0,         1'b1, 32'd1,         1'b0);
        add_const("full_prop",   32'hFFFF_FFFF, 32'd0,         1'b1, 32'd0,         1'b1);
        add_const("grp_4bit",    32'h0000_000F, 32'd1,         1'b0, 32'h0000_0010, 1'b0);
        add_const("grp_16bit",   32'h0000_FFFF, 32'd1,         1'b0, 32'h0001_0000, 1'b0);
        add_const("grp_24bit",   32'h00FF_FFFF, 32'd1,         1'b0, 32'h0100_0000, 1'b0);
        add_const("grp_28bit",   32'h0FFF_FFFF, 32'd1,         1'b0, 32'h1000_0000, 1'b0);

        // Asynchronous reset in mid-cycle, held across an edge, then released.
        add_check("pre_reset", 32'hDEAD_BEEF, 32'hF00D_CAFE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("reset_async", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_hold", 32'h0, 1'b0);
        drive(32'hCAFE_0001, 32'h3501_FFFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("reset_released", 32'h0, 1'b0);
        add_check("post_reset", 32'hCAFE_0001, 32'h3501_FFFF, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) rb = ~ra;
            add_check($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
